// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid -- two-entry registered pipeline stage with a skid buffer.
//
// Holds up to two entries: "main" drives the outputs, "skid" absorbs the one
// entry that may arrive in the cycle a downstream stall first becomes visible.
// in_ready is a pure register output, so there is no combinational path from
// out_ready back to in_ready.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   flush      synchronous clear of both entries (bubble insertion)
//   in_valid   upstream entry valid
//   in_ready   stage can accept an entry this cycle (registered)
//   in_ctrl    upstream control bits   [CTRL_W]
//   in_data    upstream payload        [DATA_W]
//   out_valid  downstream entry valid
//   out_ready  downstream accepts; low = stall
//   out_ctrl   stored control bits, zero when out_valid=0
//   out_data   stored payload,      zero when out_valid=0
//   stall_cnt  (PIPE_STAGE_SKID_PERF_EN only) edges with out_valid & ~out_ready
//   bubble_cnt (PIPE_STAGE_SKID_PERF_EN only) edges with ~out_valid
//
// Configuration macro: PIPE_STAGE_SKID_PERF_EN enables the saturating
// performance counters; they are cleared by reset only, not by flush.

module pipe_stage_skid #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_SKID_PERF_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       bubble_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;

    logic valid_int;
    logic accept;
    logic issue;

    assign valid_int = (state_q != EMPTY);
    assign accept    = in_valid & in_ready_q;
    assign issue     = valid_int & out_ready;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
        end
    end

    // Next-state logic. Vacated entries are zeroed so that the outputs read
    // zero whenever out_valid is low without any output-side masking.
    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;

        if (flush) begin
            state_d     = EMPTY;
            main_ctrl_d = '0;
            main_data_d = '0;
            skid_ctrl_d = '0;
            skid_data_d = '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                        state_d     = ONE;
                    end
                end
                ONE: begin
                    if (accept && issue) begin
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end else if (accept) begin
                        skid_ctrl_d = in_ctrl;
                        skid_data_d = in_data;
                        state_d     = FULL;
                    end else if (issue) begin
                        main_ctrl_d = '0;
                        main_data_d = '0;
                        state_d     = EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so no accept can coincide.
                    if (issue) begin
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                        skid_ctrl_d = '0;
                        skid_data_d = '0;
                        state_d     = ONE;
                    end
                end
                default: begin
                    state_d     = EMPTY;
                    main_ctrl_d = '0;
                    main_data_d = '0;
                    skid_ctrl_d = '0;
                    skid_data_d = '0;
                end
            endcase
        end

        // Registered ready: computed from the next state so it tracks
        // (state != FULL) exactly in the following cycle.
        in_ready_d = (state_d != FULL);
    end

    // Output logic
    always_comb begin
        out_valid = valid_int;
        in_ready  = in_ready_q;
        out_ctrl  = main_ctrl_q;
        out_data  = main_data_q;
    end

`ifdef PIPE_STAGE_SKID_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] bubble_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (valid_int && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF))
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (!valid_int && (bubble_cnt_q != 32'hFFFF_FFFF))
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CTRL_W = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
`ifdef PIPE_STAGE_SKID_PERF_EN
    logic [31:0]       stall_cnt;
    logic [31:0]       bubble_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data)
`ifdef PIPE_STAGE_SKID_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt)
`endif
    );

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b0;
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", in_ready); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", out_data); end
        checks++; if (out_ctrl !== 4'h0) begin errors++; $display("FAIL reset_ctrl: got %h want 0", out_ctrl); end
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        in_valid = 1'b1; in_ctrl = 4'h5; in_data = 32'h11;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_rdy0: got %b want 1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h11 || out_ctrl !== 4'h5) begin errors++; $display("FAIL stream_d0: got v=%b d=%h c=%h want v=1 d=11 c=5", out_valid, out_data, out_ctrl); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_rdy1: got %b want 1", in_ready); end
        in_data = 32'h22;
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h22) begin errors++; $display("FAIL stream_d1: got v=%b d=%h want v=1 d=22", out_valid, out_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_rdy2: got %b want 1", in_ready); end
        in_data = 32'h33;
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h33) begin errors++; $display("FAIL stream_d2: got v=%b d=%h want v=1 d=33", out_valid, out_data); end
        in_valid = 1'b0; in_ctrl = '0; in_data = '0;
        tick();
        checks++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_ctrl !== 4'h0) begin errors++; $display("FAIL stream_drain: got v=%b d=%h c=%h want all 0", out_valid, out_data, out_ctrl); end
    endtask

    task automatic test_stall_fill();
        out_ready = 1'b0;
        in_valid = 1'b1; in_ctrl = 4'h3; in_data = 32'hA;
        tick();
        checks++; if (out_data !== 32'hA || in_ready !== 1'b1) begin errors++; $display("FAIL stall_a: got d=%h rdy=%b want d=a rdy=1", out_data, in_ready); end
        in_data = 32'hB;
        tick();
        checks++; if (out_data !== 32'hA || in_ready !== 1'b0) begin errors++; $display("FAIL stall_full: got d=%h rdy=%b want d=a rdy=0", out_data, in_ready); end
        in_data = 32'hC;
        tick();
        checks++; if (out_data !== 32'hA || in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL stall_hold: got d=%h rdy=%b v=%b want d=a rdy=0 v=1", out_data, in_ready, out_valid); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_data !== 32'hB || in_ready !== 1'b1) begin errors++; $display("FAIL stall_b: got d=%h rdy=%b want d=b rdy=1", out_data, in_ready); end
        tick();
        checks++; if (out_data !== 32'hC || out_valid !== 1'b1) begin errors++; $display("FAIL stall_c: got d=%h v=%b want d=c v=1", out_data, out_valid); end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin errors++; $display("FAIL stall_empty: got v=%b d=%h want v=0 d=0", out_valid, out_data); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_ctrl = 4'h9; in_data = 32'hA;
        tick();
        in_data = 32'hB;
        tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_pre_full: got rdy=%b want 0", in_ready); end
        flush = 1'b1; in_data = 32'hD;
        tick();
        checks++; if (out_valid !== 1'b0 || out_ctrl !== 4'h0 || out_data !== 32'h0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_clear: got v=%b c=%h d=%h rdy=%b want 0 0 0 1", out_valid, out_ctrl, out_data, in_ready); end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin errors++; $display("FAIL flush_no_d: got v=%b d=%h want v=0 d=0", out_valid, out_data); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_ctrl = 4'h6; in_data = 32'hA;
        tick();
        in_data = 32'hB;
        tick();
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_ctrl !== 4'h0 || in_ready !== 1'b1) begin errors++; $display("FAIL areset_now: got v=%b d=%h c=%h rdy=%b want 0 0 0 1", out_valid, out_data, out_ctrl, in_ready); end
        #1 reset = 1'b0;
        out_ready = 1'b1; in_valid = 1'b1; in_ctrl = 4'h1; in_data = 32'h7;
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h7 || out_ctrl !== 4'h1) begin errors++; $display("FAIL areset_after: got v=%b d=%h c=%h want v=1 d=7 c=1", out_valid, out_data, out_ctrl); end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_drain: got v=%b want 0", out_valid); end
    endtask

    task automatic test_bubble_counters();
        do_reset();
        out_ready = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (out_ctrl !== 4'h0 || out_valid !== 1'b0) begin errors++; $display("FAIL bubble_idle%0d: got c=%h v=%b want c=0 v=0", i, out_ctrl, out_valid); end
        end
        in_valid = 1'b1; in_ctrl = 4'hF; in_data = 32'h55;
        tick();
        in_valid = 1'b0; in_ctrl = '0; in_data = '0;
        for (int i = 0; i < 4; i++) tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h55 || out_ctrl !== 4'hF) begin errors++; $display("FAIL bubble_hold: got v=%b d=%h c=%h want v=1 d=55 c=f", out_valid, out_data, out_ctrl); end
`ifdef PIPE_STAGE_SKID_PERF_EN
        // 3 idle edges + the accepting edge (out_valid still low) = 4 bubbles.
        checks++; if (bubble_cnt !== 32'd4) begin errors++; $display("FAIL bubble_cnt: got %0d want 4", bubble_cnt); end
        checks++; if (stall_cnt !== 32'd4) begin errors++; $display("FAIL stall_cnt: got %0d want 4", stall_cnt); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (stall_cnt !== 32'd5 || bubble_cnt !== 32'd4) begin errors++; $display("FAIL cnt_after_flush: got stall=%0d bubble=%0d want 5 4", stall_cnt, bubble_cnt); end
        do_reset();
        checks++; if (stall_cnt !== 32'd0 || bubble_cnt !== 32'd0) begin errors++; $display("FAIL cnt_reset: got stall=%0d bubble=%0d want 0 0", stall_cnt, bubble_cnt); end
`endif
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_stall_fill();
        test_flush();
        test_async_reset();
        test_bubble_counters();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
